// File: rtl/softmax_stream_if.sv
// Valid/ready stream bundle for softmax_stream: score beats in, probability beats out.
// With SOFTMAX_MASK_EN defined each input lane also carries a mask bit (1 = excluded).
interface softmax_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_data;
`ifdef SOFTMAX_MASK_EN
  logic [LANES-1:0]            in_mask;
`endif
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*8-1:0]          out_data;
  logic                        out_last;

`ifdef SOFTMAX_MASK_EN
  modport slave  (input in_valid, in_data, in_mask, out_ready,
                  output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_data, in_mask, out_ready,
                  input in_ready, out_valid, out_data, out_last);
`else
  modport slave  (input in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_last);
`endif
endinterface

// File: rtl/softmax_stream.sv
// Row-wise streaming softmax: buffer a row, find max, base-2 exp approximation, sum,
// serial reciprocal, then stream 8-bit probabilities. SOFTMAX_MASK_EN adds per-lane masking.
module softmax_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ROW_LEN    = 128
) (
  input logic             clk_p,
  input logic             rst_p,
  softmax_stream_if.slave strm
);
  localparam int BEATS = ROW_LEN / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW1   = DATA_WIDTH + 1;
  localparam int SW    = 9 + $clog2(ROW_LEN) + 1;
  localparam int RW    = 17;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {LOAD = 2'd0, EXP = 2'd1, DIV = 2'd2, OUT = 2'd3} state_t;

  // d = max - x is formed one bit wider so the full signed range never wraps.
  function automatic logic [8:0] exp2_approx(input logic signed [DATA_WIDTH-1:0] mx,
                                             input logic signed [DATA_WIDTH-1:0] x);
    logic [DW1-1:0] d;
    logic [DW1-1:0] ip;
    logic [8:0]     mant;
    d  = {mx[DATA_WIDTH-1], mx} - {x[DATA_WIDTH-1], x};
    ip = d >> 2;
    case (d[1:0])
      2'd0:    mant = 9'd256;
      2'd1:    mant = 9'd215;
      2'd2:    mant = 9'd181;
      2'd3:    mant = 9'd152;
      default: mant = 9'd0;
    endcase
    if (ip >= DW1'(4'd9)) return 9'd0;
    else return mant >> ip;
  endfunction

  state_t                       state_r, state_next_s;
  logic [CW-1:0]                cnt_r;
  logic [LANES*DATA_WIDTH-1:0]  row_buf_r [BEATS];
  logic [LANES-1:0]             keep_buf_r [BEATS];
  logic signed [DATA_WIDTH-1:0] max_r, beat_max_s;
  logic                         any_r, beat_any_s;
  logic [SW-1:0]                sum_r, beat_sum_s, rem_r, rem_next_s;
  logic [SW:0]                  rem_shift_s;
  logic [RW-1:0]                quo_r, quo_next_s, recip_r;
  logic [4:0]                   div_cnt_r;
  logic                         in_ready_r, out_valid_r, out_last_r;
  logic [LANES*8-1:0]           out_data_r, prob_s;
  logic [LANES-1:0]             in_keep_s, rd_keep_s;
  logic [LANES*DATA_WIDTH-1:0]  rd_beat_s;
  logic [8:0]                   e_s [LANES];
  logic [25:0]                  prod_s [LANES];
  logic                         in_fire_s, out_fire_s, out_load_s, cnt_last_s;

`ifdef SOFTMAX_MASK_EN
  assign in_keep_s = ~strm.in_mask;
`else
  assign in_keep_s = {LANES{1'b1}};
`endif

  assign in_fire_s  = strm.in_valid && in_ready_r;
  assign out_fire_s = out_valid_r && strm.out_ready;
  assign out_load_s = (state_r == OUT) && (!out_valid_r || (strm.out_ready && !out_last_r));
  assign cnt_last_s = (cnt_r == LAST_BEAT);
  assign rd_beat_s  = row_buf_r[cnt_r];
  assign rd_keep_s  = keep_buf_r[cnt_r];

  // Fold the incoming beat's unmasked lanes into the running max.
  always_comb begin
    beat_max_s = max_r;
    beat_any_s = any_r | (|in_keep_s);
    for (int l = 0; l < LANES; l++) begin
      beat_max_s = (in_keep_s[l] &&
                    ($signed(strm.in_data[l*DATA_WIDTH +: DATA_WIDTH]) > beat_max_s))
                   ? strm.in_data[l*DATA_WIDTH +: DATA_WIDTH] : beat_max_s;
    end
  end

  // Exponentials of the addressed beat, their sum, and the scaled saturated probabilities.
  always_comb begin
    beat_sum_s = '0;
    prob_s     = '0;
    for (int l = 0; l < LANES; l++) begin
      e_s[l]    = 9'd0;
      prod_s[l] = 26'd0;
    end
    for (int l = 0; l < LANES; l++) begin
      e_s[l]     = rd_keep_s[l] ? exp2_approx(max_r, rd_beat_s[l*DATA_WIDTH +: DATA_WIDTH]) : 9'd0;
      beat_sum_s = beat_sum_s + SW'(e_s[l]);
      prod_s[l]  = e_s[l] * recip_r;
      prob_s[l*8 +: 8] = (prod_s[l][25:16] > 10'd255) ? 8'd255 : prod_s[l][23:16];
    end
  end

  // Restoring divide step for 2^24 / sum; the dividend's only set bit enters first.
  always_comb begin
    rem_shift_s = {rem_r, (div_cnt_r == 5'd0)};
    if (rem_shift_s >= {1'b0, sum_r}) begin
      rem_next_s = SW'(rem_shift_s - {1'b0, sum_r});
      quo_next_s = {quo_r[RW-2:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s[SW-1:0];
      quo_next_s = {quo_r[RW-2:0], 1'b0};
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LOAD:    if (in_fire_s && cnt_last_s) state_next_s = EXP;
               else state_next_s = LOAD;
      EXP:     if (cnt_last_s) state_next_s = any_r ? DIV : OUT;
               else state_next_s = EXP;
      DIV:     if (div_cnt_r == 5'd24) state_next_s = OUT;
               else state_next_s = DIV;
      OUT:     if (out_fire_s && out_last_r) state_next_s = LOAD;
               else state_next_s = OUT;
      default: state_next_s = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) state_r <= LOAD;
    else       state_r <= state_next_s;
  end

  // Row storage; always written before it is read, so it carries no reset.
  always_ff @(posedge clk_p) begin
    if (in_fire_s) begin
      row_buf_r[cnt_r]  <= strm.in_data;
      keep_buf_r[cnt_r] <= in_keep_s;
    end
  end

  // Counters, max/sum/divider and the registered output beat.
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      cnt_r       <= '0;
      max_r       <= MOST_NEG;
      any_r       <= 1'b0;
      sum_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      recip_r     <= '0;
      div_cnt_r   <= 5'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      in_ready_r <= (state_next_s == LOAD);
      case (state_r)
        LOAD: begin
          sum_r     <= '0;
          rem_r     <= '0;
          quo_r     <= '0;
          div_cnt_r <= 5'd0;
          if (in_fire_s) begin
            cnt_r <= cnt_last_s ? '0 : cnt_r + 1'b1;
            max_r <= beat_max_s;
            any_r <= beat_any_s;
          end
        end
        EXP: begin
          sum_r <= sum_r + beat_sum_s;
          cnt_r <= cnt_last_s ? '0 : cnt_r + 1'b1;
          if (cnt_last_s && !any_r) recip_r <= '0;
        end
        DIV: begin
          rem_r     <= rem_next_s;
          quo_r     <= quo_next_s;
          div_cnt_r <= div_cnt_r + 5'd1;
          if (div_cnt_r == 5'd24) recip_r <= quo_next_s;
        end
        OUT: begin
          if (out_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= prob_s;
            out_last_r  <= cnt_last_s;
            cnt_r       <= cnt_last_s ? '0 : cnt_r + 1'b1;
          end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            max_r       <= MOST_NEG;
            any_r       <= 1'b0;
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  assign strm.in_ready  = in_ready_r;
  assign strm.out_valid = out_valid_r;
  assign strm.out_data  = out_data_r;
  assign strm.out_last  = out_last_r;
endmodule

// File: doc/softmax_stream.md
Name: softmax_stream

Overview:
- Row-wise streaming softmax over signed fixed-point attention scores. It is the parametrised successor to the flat, whole-tensor softmax operator.
- Accepts one row of ROW_LEN elements as ROW_LEN/LANES beats on a valid/ready stream and buffers the row internally.
- Computes max, base-2 exponential approximation, sum and reciprocal, then streams out the normalised unsigned 8-bit probabilities.
- Sits between the QK^T matmul and the attention-times-V matmul. Processes rows back to back, so the matrix/head count is handled by streaming.

Parameters:
- DATA_WIDTH, 8: signed input element width.
- LANES, 4: elements per beat.
- ROW_LEN, 128: elements per row. Must be a multiple of LANES and ≤ 65536.

Ports:
- clk_p  in  1  clock, rising edge.
- rst_p  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*DATA_WIDTH  signed elements; lane 0 in the LSBs and first in row order.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*8  unsigned probabilities, 255 ≈ 1.0; lane 0 in the LSBs.
- out_last  out  1  high on the final beat of a row.

Behaviour:
- Reset and beat count:
  - Async reset forces state LOAD and clears all counters, max, sum and reciprocal.
  - Outputs during reset: in_ready=0, out_valid=0, out_data=0, out_last=0.
  - Any partial row is discarded by reset. in_ready rises on the first clock after reset deasserts.
  - BEATS = ROW_LEN/LANES.
- LOAD:
  - in_ready=1.
  - Each accepted beat is written to the row buffer at the beat counter and folded into the running signed max (lane-reduction tree).
  - After BEATS accepted beats → EXP. in_ready=0 from that cycle.
- EXP: one buffered beat read per cycle; sum accumulated; BEATS cycles → DIV.
  - Per element: d = max − x, computed as an unsigned DATA_WIDTH+1 bit value; ip = d>>2; f = d[1:0].
  - Mantissa table {256, 215, 181, 152}, indexed by f.
  - e = mant[f] >> ip. If ip ≥ 9, e = 0. e is 9 bits.
  - sum width: 9 + clog2(ROW_LEN) + 1.
- DIV:
  - Restoring serial divider computes recip = floor(2^24 / sum) in 25 cycles, 17-bit result.
  - sum ≥ 256 always, because the max element gives e = 256.
  - Then → OUT.
- OUT:
  - Buffer is re-read and e is recomputed per lane.
  - Per lane: p = (e * recip) >> 16, saturated to 255.
  - Output is registered: out_valid/out_data/out_last hold stable while out_valid && !out_ready.
  - Beat counter advances only on handshake.
  - After the last beat handshakes → LOAD, with in_ready=1 the next cycle.
- Latency: minimum row-in-to-first-output = BEATS (EXP) + 25 (DIV) + 1 cycles after the last input beat.
- Throughput: one row per ≥ 3*BEATS + 26 cycles. No input/output overlap.
- Boundaries:
  - Equal elements give uniform output.
  - Most-negative input with max at most-positive gives d = 2^DATA_WIDTH − 1 with no overflow.
  - out_ready held low indefinitely: state and data hold with no loss.
  - Reset asserted in OUT: out_valid drops immediately (async).

Optional Feature:
- Macro SOFTMAX_MASK_EN.
- Defined:
  - Adds port in_mask (in, LANES), captured per element alongside in_data.
  - A masked element is excluded from the max and forced to e = 0; its output is 0.
  - If every element of a row is masked: DIV is skipped, recip = 0, and all outputs are 0 with normal out_last/handshake.
- Undefined: no port; all elements are valid.

Test Plan (LANES=1, ROW_LEN=4 unless stated):
- Row {0,0,0,0}: sum=1024, recip=16384 → out {64,64,64,64}; out_last on 4th beat only.
- Row {4,3,0,0}: e={256,215,128,128}, sum=727, recip=23077 → out {90,75,45,45}.
- Row {100,−100,−100,−100}: others ip ≥ 9 → out {255,0,0,0} (saturation); row {127,−128,−128,−128} gives the same, checking the d width.
- Defaults (LANES=4, ROW_LEN=128):
  - Random rows checked against the bit-exact model.
  - Random out_ready duty (~30%), and in_valid gaps.
  - Check: no dropped/duplicated beats; out_data stable while stalled; in_ready=0 outside LOAD.
- Reset pulse mid-LOAD (after 2 beats) and mid-OUT:
  - Outputs go to 0 immediately.
  - The next full row {0,0,0,0} yields {64,64,64,64}, with no residue from the aborted row.
- With SOFTMAX_MASK_EN:
  - Row {4,3,0,0}, mask {0,0,1,1} → e={256,215,0,0}, sum=471, recip=35620 → out {139,116,0,0}.
  - All masked → out {0,0,0,0}.
